// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between the NPC master and the data SRAM model.
// Five channels, each with its own valid/ready pair.
interface axi_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   AW_ADDR;
  logic                    AW_VALID;
  logic                    AW_READY;
  logic [DATA_WIDTH-1:0]   W_DATA;
  logic [DATA_WIDTH/8-1:0] W_STRB;
  logic                    W_VALID;
  logic                    W_READY;
  logic [1:0]              B_RESP;
  logic                    B_VALID;
  logic                    B_READY;
  logic [ADDR_WIDTH-1:0]   AR_ADDR;
  logic                    AR_VALID;
  logic                    AR_READY;
  logic [DATA_WIDTH-1:0]   R_DATA;
  logic [1:0]              R_RESP;
  logic                    R_VALID;
  logic                    R_READY;

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID,
    input  B_READY, AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_RESP, B_VALID,
    output AR_READY, R_DATA, R_RESP, R_VALID
  );

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID,
    output B_READY, AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_RESP, B_VALID,
    input  AR_READY, R_DATA, R_RESP, R_VALID
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite SRAM slave: independent read/write engines with
// programmable latency, byte strobes and DECERR outside the window.
module axi_lite_sram_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1
) (
  input logic CLK,
  input logic RESETN,
  axi_lite_sram_slave_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WIN =
    ADDR_WIDTH'(MEM_DEPTH * NB);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {WIDLE, WLAT, WRESP} wst_t;
  typedef enum logic [1:0] {RIDLE, RLAT, RDATA} rdst_t;

  wst_t  ws, ws_n;
  rdst_t rs, rs_n;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  aw_got, w_got;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;
  logic [7:0]            wcnt, rcnt;
  logic [1:0]            b_resp, r_resp;
  logic [DATA_WIDTH-1:0] r_data;

  logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
  logic aw_hs, w_hs, ar_hs;
  logic w_go, w_commit, r_sample;

  logic [ADDR_WIDTH-1:0] w_off, r_off;
  logic                  w_in, r_in;
  logic [IDX_W-1:0]      w_idx, r_idx;

  assign aw_hs = bus.AW_VALID && aw_rdy;
  assign w_hs  = bus.W_VALID && w_rdy;
  assign ar_hs = bus.AR_VALID && ar_rdy;

  assign w_go = (ws == WIDLE)
    && (aw_got || aw_hs) && (w_got || w_hs);
  assign w_commit = (ws == WLAT) && (wcnt == '0);
  assign r_sample = (rs == RLAT) && (rcnt == '0);

  // Unsigned offset check covers both window bounds
  assign w_off = aw_addr - BASE_ADDR;
  assign w_in  = (aw_addr >= BASE_ADDR) && (w_off < WIN);
  assign w_idx = IDX_W'(w_off >> OFF_W);
  assign r_off = ar_addr - BASE_ADDR;
  assign r_in  = (ar_addr >= BASE_ADDR) && (r_off < WIN);
  assign r_idx = IDX_W'(r_off >> OFF_W);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      ws <= WIDLE;
      rs <= RIDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  end

  always_comb begin
    ws_n = ws;
    unique case (ws)
      WIDLE:   if (w_go) ws_n = WLAT;
      WLAT:    if (wcnt == '0) ws_n = WRESP;
      WRESP:   if (bus.B_READY) ws_n = WIDLE;
      default: ws_n = WIDLE;
    endcase
  end

  always_comb begin
    rs_n = rs;
    unique case (rs)
      RIDLE:   if (ar_hs) rs_n = RLAT;
      RLAT:    if (rcnt == '0) rs_n = RDATA;
      RDATA:   if (bus.R_READY) rs_n = RIDLE;
      default: rs_n = RIDLE;
    endcase
  end

  always_comb begin
    aw_rdy = (ws == WIDLE) && !aw_got;
    w_rdy  = (ws == WIDLE) && !w_got;
    ar_rdy = (rs == RIDLE);
    b_vld  = (ws == WRESP);
    r_vld  = (rs == RDATA);
  end

  assign bus.AW_READY = aw_rdy;
  assign bus.W_READY  = w_rdy;
  assign bus.AR_READY = ar_rdy;
  assign bus.B_VALID  = b_vld;
  assign bus.B_RESP   = b_resp;
  assign bus.R_VALID  = r_vld;
  assign bus.R_RESP   = r_resp;
  assign bus.R_DATA   = r_data;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      wcnt    <= '0;
      rcnt    <= '0;
      b_resp  <= OKAY;
      r_resp  <= OKAY;
      r_data  <= '0;
    end else begin
      if (aw_hs) begin
        aw_got  <= 1'b1;
        aw_addr <= bus.AW_ADDR;
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= bus.W_DATA;
        w_strb <= bus.W_STRB;
      end
      if (b_vld && bus.B_READY) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (w_go)
        wcnt <= 8'(WRITE_LAT);
      else if (ws == WLAT && wcnt != '0)
        wcnt <= wcnt - 8'd1;
      if (w_commit)
        b_resp <= w_in ? OKAY : DECERR;
      if (ar_hs) begin
        ar_addr <= bus.AR_ADDR;
        rcnt    <= 8'(READ_LAT);
      end else if (rs == RLAT && rcnt != '0) begin
        rcnt <= rcnt - 8'd1;
      end
      // Same-edge commit is not yet visible: read-before-write
      if (r_sample) begin
        r_data <= r_in ? mem[r_idx] : '0;
        r_resp <= r_in ? OKAY : DECERR;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESETN && w_commit && w_in) begin
      for (int k = 0; k < NB; k++) begin
        if (w_strb[k])
          mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Randomised AXI-Lite master against a transaction-level model of the SRAM slave.
// Directed cases pin the model with literal expectations.
module tb_axi_lite_sram_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] WEND = 64'h8000_2000;
  localparam int RL = 2;
  localparam int WL = 1;

  logic CLK;
  logic RESETN;
  int   n_chk;
  int   n_fail;

  axi_lite_sram_slave_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  axi_lite_sram_slave #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(1024),
    .BASE_ADDR(64'h8000_0000), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic bit inwin(input logic [63:0] a);
    return (a >= BASE) && (a < WEND);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  function automatic logic [63:0] smask(input logic [7:0] s);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  // Transaction-level model: edge numbers and latency rules, flat word array
  logic [63:0] m_mem [1024];
  int          ecnt;
  logic        m_on, m_rst_last;
  logic        m_awg, m_wg, m_wbusy, m_rbusy;
  logic [63:0] m_wa, m_wd, m_ra, m_rdata;
  logic [7:0]  m_ws;
  int          m_bdue, m_rdue;
  logic [1:0]  m_bresp, m_rresp;

  logic e_aw_rdy, e_w_rdy, e_ar_rdy, e_bv, e_rv;
  logic m_aw_hs, m_w_hs, m_ar_hs;
  assign e_aw_rdy = !m_wbusy && !m_awg;
  assign e_w_rdy  = !m_wbusy && !m_wg;
  assign e_ar_rdy = !m_rbusy;
  assign e_bv     = m_wbusy && (ecnt >= m_bdue);
  assign e_rv     = m_rbusy && (ecnt >= m_rdue);
  assign m_aw_hs  = bus.AW_VALID && e_aw_rdy;
  assign m_w_hs   = bus.W_VALID && e_w_rdy;
  assign m_ar_hs  = bus.AR_VALID && e_ar_rdy;

  initial begin
    ecnt = 0;
    m_on = 1'b0;
    m_rst_last = 1'b0;
  end

  always @(posedge CLK) begin
    ecnt <= ecnt + 1;
    if (!RESETN) begin
      m_on       <= 1'b1;
      m_rst_last <= 1'b1;
      m_awg      <= 1'b0;
      m_wg       <= 1'b0;
      m_wbusy    <= 1'b0;
      m_rbusy    <= 1'b0;
      m_bresp    <= 2'b00;
      m_rresp    <= 2'b00;
      m_rdata    <= '0;
    end else begin
      m_rst_last <= 1'b0;
      if (!m_wbusy) begin
        if (m_aw_hs) begin
          m_awg <= 1'b1;
          m_wa  <= bus.AW_ADDR;
        end
        if (m_w_hs) begin
          m_wg <= 1'b1;
          m_wd <= bus.W_DATA;
          m_ws <= bus.W_STRB;
        end
        if ((m_awg || m_aw_hs) && (m_wg || m_w_hs)) begin
          m_wbusy <= 1'b1;
          m_bdue  <= ecnt + 2 + WL;
        end
      end else begin
        if (ecnt + 1 == m_bdue) begin
          if (inwin(m_wa))
            m_mem[widx(m_wa)] <= (m_mem[widx(m_wa)] & ~smask(m_ws))
                               | (m_wd & smask(m_ws));
          m_bresp <= inwin(m_wa) ? 2'b00 : 2'b11;
        end
        if (ecnt >= m_bdue && bus.B_READY) begin
          m_wbusy <= 1'b0;
          m_awg   <= 1'b0;
          m_wg    <= 1'b0;
        end
      end
      if (!m_rbusy) begin
        if (m_ar_hs) begin
          m_rbusy <= 1'b1;
          m_ra    <= bus.AR_ADDR;
          m_rdue  <= ecnt + 2 + RL;
        end
      end else begin
        if (ecnt + 1 == m_rdue) begin
          m_rdata <= inwin(m_ra) ? m_mem[widx(m_ra)] : 64'h0;
          m_rresp <= inwin(m_ra) ? 2'b00 : 2'b11;
        end
        if (ecnt >= m_rdue && bus.R_READY) m_rbusy <= 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (m_on) begin
      chk("aw_ready", bus.AW_READY, e_aw_rdy);
      chk("w_ready",  bus.W_READY,  e_w_rdy);
      chk("ar_ready", bus.AR_READY, e_ar_rdy);
      chk("b_valid",  bus.B_VALID,  e_bv);
      chk("r_valid",  bus.R_VALID,  e_rv);
      if (e_bv || m_rst_last) chk("b_resp", bus.B_RESP, m_bresp);
      if (e_rv || m_rst_last) begin
        chk("r_resp", bus.R_RESP, m_rresp);
        chk("r_data", bus.R_DATA, m_rdata);
      end
    end
  end

  task automatic wr(input logic [63:0] a, input logic [63:0] d,
                    input logic [7:0] s, input int wlead, input int bwait,
                    output logic [1:0] resp, output int lat);
    int t, aw_at, w_at, hs_e;
    bit awd, wd, af, wf;
    aw_at = (wlead > 0) ? wlead : 0;
    w_at  = (wlead < 0) ? -wlead : 0;
    awd = 0; wd = 0; t = 0; hs_e = 0;
    resp = 2'b01; lat = -1;
    @(negedge CLK);
    bus.AW_ADDR = a;
    bus.W_DATA  = d;
    bus.W_STRB  = s;
    while (!(awd && wd) && t < 100) begin
      bus.AW_VALID = (t >= aw_at) && !awd;
      bus.W_VALID  = (t >= w_at) && !wd;
      af = bus.AW_VALID && bus.AW_READY;
      wf = bus.W_VALID && bus.W_READY;
      @(negedge CLK);
      t++;
      if (af) awd = 1;
      if (wf) wd = 1;
      if (awd && wd) hs_e = ecnt;
    end
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    if (!(awd && wd)) begin
      chk("wr_handshake_timeout", 0, 1);
      return;
    end
    t = 0;
    while (!bus.B_VALID && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.B_VALID) begin
      chk("b_valid_timeout", 0, 1);
      return;
    end
    lat  = ecnt - hs_e;
    resp = bus.B_RESP;
    repeat (bwait) @(negedge CLK);
    bus.B_READY = 1'b1;
    @(negedge CLK);
    bus.B_READY = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, input int rwait, input bit poke,
                    output logic [63:0] data, output logic [1:0] resp,
                    output int lat);
    int t, hs_e;
    bit done, af;
    t = 0; done = 0; hs_e = 0;
    data = '1; resp = 2'b01; lat = -1;
    @(negedge CLK);
    bus.AR_ADDR  = a;
    bus.AR_VALID = 1'b1;
    while (!done && t < 100) begin
      af = bus.AR_VALID && bus.AR_READY;
      @(negedge CLK);
      t++;
      done = af;
    end
    bus.AR_VALID = 1'b0;
    hs_e = ecnt;
    if (!done) begin
      chk("rd_handshake_timeout", 0, 1);
      return;
    end
    t = 0;
    while (!bus.R_VALID && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.R_VALID) begin
      chk("r_valid_timeout", 0, 1);
      return;
    end
    lat  = ecnt - hs_e;
    data = bus.R_DATA;
    resp = bus.R_RESP;
    if (poke) bus.AR_VALID = 1'b1;
    repeat (rwait) @(negedge CLK);
    bus.AR_VALID = 1'b0;
    bus.R_READY  = 1'b1;
    @(negedge CLK);
    bus.R_READY = 1'b0;
  endtask

  function automatic logic [63:0] raddr();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return WEND + 64'($urandom_range(0, 64));
    if (sel == 1) return 64'h7FFF_FFF8 - 64'($urandom_range(0, 64));
    return BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [1:0]  resp;
    logic [63:0] d;
    int          lat, t;
    n_chk = 0;
    n_fail = 0;
    RESETN = 1'b0;
    bus.AW_ADDR = '0; bus.AW_VALID = 1'b0;
    bus.W_DATA = '0;  bus.W_STRB = '0; bus.W_VALID = 1'b0;
    bus.B_READY = 1'b0;
    bus.AR_ADDR = '0; bus.AR_VALID = 1'b0;
    bus.R_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    chk("rst_aw_ready", bus.AW_READY, 1);
    chk("rst_w_ready",  bus.W_READY,  1);
    chk("rst_ar_ready", bus.AR_READY, 1);
    chk("rst_b_valid",  bus.B_VALID,  0);
    chk("rst_r_valid",  bus.R_VALID,  0);
    chk("rst_r_data",   bus.R_DATA,   0);

    // Basic write/read with latencies
    wr(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, resp, lat);
    chk("t1_b_resp", resp, 2'b00);
    chk("t1_b_lat", lat, 2);
    rd(64'h8000_0010, 0, 0, d, resp, lat);
    chk("t1_r_data", d, 64'h0123_4567_89AB_CDEF);
    chk("t1_r_resp", resp, 2'b00);
    chk("t1_r_lat", lat, 3);
    chk("t1_model_word", m_mem[2], 64'h0123_4567_89AB_CDEF);

    // Partial strobe merge
    wr(64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1, resp, lat);
    wr(64'h8000_0020, 64'h0, 8'h0F, 0, 0, resp, lat);
    rd(64'h8000_0020, 1, 0, d, resp, lat);
    chk("t2_strobe_merge", d, 64'hFFFF_FFFF_0000_0000);

    // W three cycles ahead of AW
    wr(64'h8000_0030, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 3, 0, resp, lat);
    chk("t3_b_resp", resp, 2'b00);
    chk("t3_b_lat", lat, 2);
    rd(64'h8000_0030, 0, 0, d, resp, lat);
    chk("t3_r_data", d, 64'hDEAD_BEEF_CAFE_F00D);

    // Out-of-window on both sides
    wr(64'h8000_0000, 64'h1111_2222_3333_4444, 8'hFF, -1, 0, resp, lat);
    rd(64'h7FFF_FFF8, 0, 0, d, resp, lat);
    chk("t4_r_resp_low", resp, 2'b11);
    chk("t4_r_data_low", d, 64'h0);
    wr(64'h8000_2000, 64'h9999_9999_9999_9999, 8'hFF, 0, 0, resp, lat);
    chk("t4_b_resp_high", resp, 2'b11);
    rd(64'h8000_0000, 0, 0, d, resp, lat);
    chk("t4_word0_intact", d, 64'h1111_2222_3333_4444);
    rd(64'h8000_2000, 0, 0, d, resp, lat);
    chk("t4_r_resp_high", resp, 2'b11);

    // Long B/R stalls; extra AR held during R stall
    wr(64'h8000_0040, 64'h0F0F_0F0F_1234_5678, 8'hFF, 0, 5, resp, lat);
    chk("t5_b_resp", resp, 2'b00);
    rd(64'h8000_0040, 5, 1, d, resp, lat);
    chk("t5_r_data", d, 64'h0F0F_0F0F_1234_5678);

    // Read sample and write commit on the same edge
    wr(64'h8000_0060, 64'hAAAA_0000_AAAA_0000, 8'hFF, 0, 0, resp, lat);
    fork
      begin
        @(negedge CLK);
        wr(64'h8000_0060, 64'h5555_1111_5555_1111, 8'hFF, 0, 0, resp, lat);
      end
      begin
        logic [63:0] d2;
        logic [1:0]  r2;
        int          l2;
        rd(64'h8000_0060, 0, 0, d2, r2, l2);
        chk("t6_read_old", d2, 64'hAAAA_0000_AAAA_0000);
      end
    join
    rd(64'h8000_0060, 0, 0, d, resp, lat);
    chk("t6_read_new", d, 64'h5555_1111_5555_1111);

    // Reset while a read waits out its latency
    @(negedge CLK);
    bus.AR_ADDR = 64'h8000_0010;
    bus.AR_VALID = 1'b1;
    @(negedge CLK);
    bus.AR_VALID = 1'b0;
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    chk("t7_rlat_rst_rvalid", bus.R_VALID, 0);
    chk("t7_rlat_rst_arready", bus.AR_READY, 1);
    repeat (4) @(negedge CLK);
    chk("t7_rlat_rst_quiet", bus.R_VALID, 0);

    // Reset during write latency drops the write
    bus.AW_ADDR = 64'h8000_0010;
    bus.W_DATA = 64'h5555_5555_5555_5555;
    bus.W_STRB = 8'hFF;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    @(negedge CLK);
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    chk("t8_wlat_rst_bvalid", bus.B_VALID, 0);
    repeat (3) @(negedge CLK);
    chk("t8_wlat_rst_quiet", bus.B_VALID, 0);
    rd(64'h8000_0010, 0, 0, d, resp, lat);
    chk("t8_not_committed", d, 64'h0123_4567_89AB_CDEF);

    // Reset while B is pending: write already committed
    @(negedge CLK);
    bus.AW_ADDR = 64'h8000_0050;
    bus.W_DATA = 64'hA5A5_A5A5_5A5A_5A5A;
    bus.AW_VALID = 1'b1;
    bus.W_VALID = 1'b1;
    @(negedge CLK);
    bus.AW_VALID = 1'b0;
    bus.W_VALID = 1'b0;
    t = 0;
    while (!bus.B_VALID && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("t9_b_seen", bus.B_VALID, 1);
    repeat (2) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    chk("t9_wresp_rst_bvalid", bus.B_VALID, 0);
    rd(64'h8000_0050, 0, 0, d, resp, lat);
    chk("t9_committed", d, 64'hA5A5_A5A5_5A5A_5A5A);

    // Random traffic on 16 words plus out-of-window addresses
    for (int i = 0; i < 16; i++)
      wr(BASE + 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 0, 0, resp, lat);
    fork
      begin
        logic [1:0] wr_r;
        int         wr_l;
        for (int i = 0; i < 60; i++) begin
          wr(raddr(), {$urandom, $urandom}, 8'($urandom),
             int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)),
             wr_r, wr_l);
          chk("rand_b_lat", wr_l, 2);
        end
      end
      begin
        logic [63:0] rd_d;
        logic [1:0]  rd_r;
        int          rd_l;
        for (int i = 0; i < 60; i++) begin
          rd(raddr(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             rd_d, rd_r, rd_l);
          chk("rand_r_lat", rd_l, 3);
        end
      end
    join
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
